bus_arbiter_rr: RTL and testbench



---
 rtl/bus_arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin / fixed-priority arbiter for the shared system bus.
// Active-low request/grant pairs, zero-idle-cycle handover between masters,
// and optional maximum-tenure preemption so one master cannot starve others.
// All outputs are registered; a request seen at one edge is granted after it.
module bus_arbiter_rr #(
  parameter int N_MASTERS  = 4,
  parameter int IDX_W      = 2,
  parameter int MAX_TENURE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rr_en,
  input  logic [N_MASTERS-1:0] req_n,
  output logic [N_MASTERS-1:0] grnt_n,
  output logic [IDX_W-1:0]     owner,
  output logic                 bus_busy,
  output logic                 preempt
);

  // Counter only needs to reach MAX_TENURE; keep one bit when tenure is unlimited.
  localparam int TEN_W = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam logic [TEN_W-1:0]     TEN_SAT = TEN_W'(MAX_TENURE);
  localparam logic [N_MASTERS-1:0] ONE     = N_MASTERS'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_reg, state_next;
  logic [N_MASTERS-1:0]   grnt_n_reg, grnt_n_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [IDX_W-1:0]       last_reg, last_next;
  logic [TEN_W-1:0]       tenure_reg, tenure_next;
  logic                   preempt_reg, preempt_next;

  logic [N_MASTERS-1:0]   req;       // active-high view of the requests
  logic [N_MASTERS-1:0]   others;    // requests from everyone except the owner
  logic [N_MASTERS-1:0]   cand;      // masters eligible in this decision
  logic [N_MASTERS-1:0]   rot;       // cand rotated into search order
  logic                   owner_req;
  logic                   expired;
  logic                   do_preempt;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  int                     start;

  assign req = ~req_n;

  // Mask the current owner out of the request vector.
  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_others
      assign others[gi] = req[gi] && (owner_reg != IDX_W'(gi));
    end
  endgenerate

  assign owner_req  = |(req & ~others);
  // The owner has held the bus for MAX_TENURE cycles once this edge completes.
  assign expired    = (MAX_TENURE > 0) && ((int'(tenure_reg) + 1) >= MAX_TENURE);
  assign do_preempt = (state_reg == GRANT) && owner_req && expired && (|others);
  // On preemption the current owner is excluded from the search.
  assign cand       = do_preempt ? others : req;

  // Pick the first eligible master, starting after last_owner in round-robin mode.
  always_comb begin
    start     = rr_en ? ((int'(last_reg) + 1) % N_MASTERS) : 0;
    rot       = N_MASTERS'({cand, cand} >> start);
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!sel_valid && rot[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'((start + k) % N_MASTERS);
      end
    end
  end

  // Next-state and next-output decision for the grant FSM.
  always_comb begin
    logic new_grant;
    state_next   = state_reg;
    grnt_n_next  = grnt_n_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    tenure_next  = tenure_reg;
    preempt_next = 1'b0;
    new_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) new_grant = 1'b1;
      end
      GRANT: begin
        if (owner_req) begin
          if (do_preempt) begin
            new_grant    = 1'b1;
            preempt_next = 1'b1;
          end else if (tenure_reg != TEN_SAT) begin
            tenure_next = tenure_reg + 1'b1;
          end
        end else if (sel_valid) begin
          new_grant = 1'b1;
        end else begin
          state_next  = IDLE;
          grnt_n_next = '1;
        end
      end
      default: begin
        state_next  = IDLE;
        grnt_n_next = '1;
      end
    endcase
    if (new_grant) begin
      state_next  = GRANT;
      owner_next  = sel_idx;
      last_next   = sel_idx;
      grnt_n_next = ~(ONE << sel_idx);
      tenure_next = '0;
    end
  end

  // State and output registers; reset releases any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grnt_n_reg  <= '1;
      owner_reg   <= '0;
      last_reg    <= IDX_W'(N_MASTERS - 1);
      tenure_reg  <= '0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grnt_n_reg  <= grnt_n_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      tenure_reg  <= tenure_next;
      preempt_reg <= preempt_next;
    end
  end

  assign grnt_n   = grnt_n_reg;
  assign owner    = owner_reg;
  assign bus_busy = (state_reg == GRANT);
  assign preempt  = preempt_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr: two instances (tenure 4 and unlimited) share
// one stimulus stream; a behavioural model checks both every cycle, and
// directed scenarios pin literal grant patterns.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic       rr_en;
  logic [3:0] req_n;

  logic [3:0] grnt_n_t, grnt_n_u;
  logic [1:0] owner_t, owner_u;
  logic       busy_t, busy_u, pre_t, pre_u;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N_MASTERS(4), .IDX_W(2), .MAX_TENURE(4)) dut_t (
    .clk(clk), .reset(reset), .rr_en(rr_en), .req_n(req_n),
    .grnt_n(grnt_n_t), .owner(owner_t), .bus_busy(busy_t), .preempt(pre_t)
  );

  bus_arbiter_rr #(.N_MASTERS(4), .IDX_W(2), .MAX_TENURE(0)) dut_u (
    .clk(clk), .reset(reset), .rr_en(rr_en), .req_n(req_n),
    .grnt_n(grnt_n_u), .owner(owner_u), .bus_busy(busy_u), .preempt(pre_u)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_busy[2], m_owner[2], m_last[2], m_held[2], m_pre[2];
  int m_ten[2] = '{4, 0};

  function automatic int pick(input logic [3:0] r, input bit rr, input int last);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = rr ? ((last + 1 + k) % 4) : k;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_busy[i] = 0; m_owner[i] = 0; m_last[i] = 3; m_held[i] = 0; m_pre[i] = 0;
  endtask

  task automatic model_grant(input int i, input int s);
    m_busy[i] = 1; m_owner[i] = s; m_last[i] = s; m_held[i] = 1;
  endtask

  task automatic model_step(input int i, input logic [3:0] r, input bit rr);
    logic [3:0] oth;
    m_pre[i] = 0;
    if (m_busy[i] == 0) begin
      if (r != 4'b0000) model_grant(i, pick(r, rr, m_last[i]));
    end else if (r[m_owner[i]]) begin
      oth = r & ~(4'b0001 << m_owner[i]);
      if (m_ten[i] > 0 && m_held[i] >= m_ten[i] && oth != 4'b0000) begin
        model_grant(i, pick(oth, rr, m_last[i]));
        m_pre[i] = 1;
      end else if (m_held[i] < 1000000) begin
        m_held[i]++;
      end
    end else if (r != 4'b0000) begin
      model_grant(i, pick(r, rr, m_last[i]));
    end else begin
      m_busy[i] = 0;
    end
  endtask

  function automatic int exp_grnt(input int i);
    logic [3:0] g;
    g = 4'b1111;
    if (m_busy[i] != 0) g = ~(4'b0001 << m_owner[i]);
    return int'(g);
  endfunction

  // Advance the model at each edge and compare both instances just after it.
  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) model_reset(i);
      else model_step(i, ~req_n, rr_en);
    end
    #1;
    check("t.grnt_n",  int'(grnt_n_t), exp_grnt(0));
    check("t.owner",   int'(owner_t),  m_owner[0]);
    check("t.busy",    int'(busy_t),   m_busy[0]);
    check("t.preempt", int'(pre_t),    m_pre[0]);
    check("u.grnt_n",  int'(grnt_n_u), exp_grnt(1));
    check("u.owner",   int'(owner_u),  m_owner[1]);
    check("u.busy",    int'(busy_u),   m_busy[1]);
    check("u.preempt", int'(pre_u),    m_pre[1]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int exp;
    reset = 1'b0; rr_en = 1'b0; req_n = 4'b1111;
    step(); step();
    check("rst.grnt_n", int'(grnt_n_t), 15);
    check("rst.owner",  int'(owner_t),  0);
    check("rst.busy",   int'(busy_t),   0);
    check("rst.preempt", int'(pre_t),   0);
    reset = 1'b1;

    // single request, one-edge latency, idle return keeps owner
    req_n = 4'b1011; step();
    check("lat.grnt_n", int'(grnt_n_t), 4'b1011);
    req_n = 4'b1111; step();
    check("idle.grnt_n", int'(grnt_n_t), 15);
    check("idle.busy",   int'(busy_t),   0);
    check("idle.owner",  int'(owner_t),  2);

    // fixed priority, zero-idle handover (unlimited-tenure instance)
    req_n = 4'b1110; step();
    check("fp.m0", int'(grnt_n_u), 4'b1110);
    req_n = 4'b1100; step();
    check("fp.hold", int'(grnt_n_u), 4'b1110);
    step();
    req_n = 4'b1101; step();
    check("fp.hand.grnt", int'(grnt_n_u), 4'b1101);
    check("fp.hand.owner", int'(owner_u), 1);
    check("fp.hand.busy", int'(busy_u), 1);
    req_n = 4'b0011; step();
    check("fp.m2", int'(grnt_n_u), 4'b1011);
    req_n = 4'b0111; step();
    check("fp.m3", int'(grnt_n_u), 4'b0111);
    req_n = 4'b1111; step();

    // round robin with all requesting, order 0,1,2,3,0
    rr_en = 1'b1;
    req_n = 4'b0000; step();
    for (int i = 0; i < 5; i++) begin
      exp = i % 4;
      check("rr.owner", int'(owner_t), exp);
      check("rr.owner_u", int'(owner_u), exp);
      req_n = 4'b0000; step();
      req_n = 4'b0001 << exp; step();
    end
    req_n = 4'b1111; step();

    // preemption after four grant cycles
    req_n = 4'b1101; step();
    check("pre.m1", int'(owner_t), 1);
    req_n = 4'b1001; step();
    check("pre.hold2", int'(pre_t), 0);
    step(); step();
    check("pre.hold4", int'(owner_t), 1);
    step();
    check("pre.owner", int'(owner_t), 2);
    check("pre.pulse", int'(pre_t), 1);
    check("pre.grnt", int'(grnt_n_t), 4'b1011);
    check("pre.u_keeps", int'(owner_u), 1);
    step();
    check("pre.pulse_end", int'(pre_t), 0);
    check("pre.owner2", int'(owner_t), 2);
    req_n = 4'b1111; step();
    req_n = 4'b1101; step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("solo.owner", int'(owner_t), 1);
      check("solo.preempt", int'(pre_t), 0);
    end
    req_n = 4'b1111; step();

    // release on the edge tenure expires, then rr_en toggle mid-grant
    req_n = 4'b1101; step();
    req_n = 4'b1001; step(); step(); step();
    req_n = 4'b1011; step();
    check("sim.owner", int'(owner_t), 2);
    check("sim.preempt", int'(pre_t), 0);
    req_n = 4'b1010; step();
    rr_en = 1'b0; step();
    check("tog.grnt", int'(grnt_n_t), 4'b1011);
    req_n = 4'b1110; step();
    check("tog.m0", int'(owner_t), 0);
    req_n = 4'b1111; step();

    // asynchronous reset during a grant
    rr_en = 1'b1;
    req_n = 4'b0111; step();
    check("ar.m3", int'(grnt_n_t), 4'b0111);
    #2 reset = 1'b0;
    #1;
    check("ar.grnt_n", int'(grnt_n_t), 15);
    check("ar.busy",   int'(busy_t),   0);
    check("ar.owner",  int'(owner_t),  0);
    check("ar.grnt_u", int'(grnt_n_u), 15);
    step();
    check("ar.held_busy", int'(busy_t), 0);
    step();
    reset = 1'b1; step();
    check("ar.regrant", int'(owner_t), 3);
    check("ar.rebusy", int'(busy_t), 1);
    req_n = 4'b1111; step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 99) < 15) req_n[b] = ~req_n[b];
      if ($urandom_range(0, 99) < 2) rr_en = ~rr_en;
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b0; step(); reset = 1'b1;
      end
      step();
    end
    req_n = 4'b1111; step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
